// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one full-adder slice, LSB first, start/busy/done handshake
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_next;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic carry, s, co, last;
    assign s    = a_sr[0] ^ b_sr[0] ^ carry;
    assign co   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last = count == CW'(WIDTH - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_comb
        state_next = state == IDLE  ? (start ? SHIFT : IDLE) :
                     state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end
    // subtraction runs as A + ~B + ~cin, so cout=1 means no borrow
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_sr  <= data_a;
                b_sr  <= sub ? ~data_b : data_b;
                carry <= sub ? ~cin : cin;
                count <= '0;
            end
        end else if (state == SHIFT) begin
            carry <= co;
            s_sr  <= {s, s_sr[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            count <= count + 1'b1;
            if (last) begin
                result <= {s, s_sr[WIDTH-1:1]};
                cout   <= co;
                ovf    <= carry ^ co;
            end
        end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors for 4-bit and 8-bit instances of serial_addsub
module tb_serial_addsub;
    logic clk = 1'b0, reset = 1'b1, sub = 1'b0, cin = 1'b0;
    logic start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, res4;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic busy4, done4, cout4, ovf4, busy8, done8, cout8, ovf8;
    int n_vec = 0, n_err = 0;
    int lat, dones;
    logic [3:0] prev;
    logic partial;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub), .cin(cin),
        .data_a(a4), .data_b(b4), .busy(busy4), .done(done4),
        .result(res4), .cout(cout4), .ovf(ovf4)
    );
    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub), .cin(cin),
        .data_a(a8), .data_b(b8), .busy(busy8), .done(done8),
        .result(res8), .cout(cout8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // returns at the negedge where done is first seen; lat counts cycles after the start edge
    task automatic run(input bit wide, input logic s, input logic c,
                       input logic [7:0] a, input logic [7:0] b, output int l);
        @(negedge clk);
        sub = s;
        cin = c;
        if (wide) begin a8 = a; b8 = b; start8 = 1'b1; end
        else begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        sub = ~s;
        cin = ~c;
        l = 0;
        while (!(wide ? done8 : done4) && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_res4", res4, 0);
        check("rst_cout4", cout4, 0);
        check("rst_ovf4", ovf4, 0);
        check("rst_busy8", busy8, 0);
        check("rst_res8", res8, 0);
        reset = 1'b0;

        run(0, 0, 0, 5, 3, lat);
        check("t1_lat", lat, 4);
        check("t1_res", res4, 8);
        check("t1_cout", cout4, 0);
        check("t1_ovf", ovf4, 1);
        check("t1_busy", busy4, 1);

        run(0, 0, 0, 15, 1, lat);
        check("t2_lat", lat, 4);
        check("t2_res", res4, 0);
        check("t2_cout", cout4, 1);
        check("t2_ovf", ovf4, 0);
        run(0, 0, 1, 6, 7, lat);
        check("t2b_lat", lat, 4);
        check("t2b_res", res4, 14);
        check("t2b_cout", cout4, 0);
        check("t2b_ovf", ovf4, 1);

        run(0, 1, 0, 3, 5, lat);
        check("t3a_res", res4, 14);
        check("t3a_cout", cout4, 0);
        check("t3a_ovf", ovf4, 0);
        run(0, 1, 1, 7, 2, lat);
        check("t3c_res", res4, 4);
        check("t3c_cout", cout4, 1);
        check("t3c_ovf", ovf4, 0);
        run(0, 1, 0, 8, 1, lat);
        check("t3b_lat", lat, 4);
        check("t3b_res", res4, 7);
        check("t3b_cout", cout4, 1);
        check("t3b_ovf", ovf4, 1);

        @(negedge clk);
        sub = 1'b0;
        cin = 1'b0;
        a4 = 4'd1;
        b4 = 4'd1;
        start4 = 1'b1;
        prev = res4;
        dones = 0;
        partial = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) dones++;
            else if (dones == 0 && res4 !== prev) partial = 1'b1;
        end
        start4 = 1'b0;
        check("t4_dones", dones, 2);
        check("t4_held", partial, 0);
        check("t4_res", res4, 2);

        @(negedge clk);
        sub = 1'b0;
        cin = 1'b0;
        a4 = 4'd7;
        b4 = 4'd7;
        start4 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_busy", busy4, 0);
        check("t5_done", done4, 0);
        check("t5_res", res4, 0);
        check("t5_cout", cout4, 0);
        @(negedge clk);
        reset = 1'b0;
        run(0, 0, 0, 2, 2, lat);
        check("t5_lat", lat, 4);
        check("t5_sum", res4, 4);
        check("t5_ovf", ovf4, 0);

        run(1, 0, 1, 200, 100, lat);
        check("t6_lat", lat, 8);
        check("t6_res", res8, 45);
        check("t6_cout", cout8, 1);
        check("t6_ovf", ovf8, 0);
        run(1, 1, 0, 100, 200, lat);
        check("t6b_res", res8, 156);
        check("t6b_cout", cout8, 0);
        check("t6b_ovf", ovf8, 1);
        @(negedge clk);
        check("t6_done_pulse", done8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
